// File: rtl/pcm_pkg.sv
// pcm_pkg: shared types and constants for the PCM memory responder
package pcm_pkg;
  localparam int PCM_N_CPU = 4;
  localparam int PCM_AW = 11;
  localparam int PCM_DW = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} pcm_state_e;
  typedef struct packed {
    logic we;
    logic [15:0] addr;
    logic [PCM_DW-1:0] wdata;
    logic [1:0] ben;
  } pcm_op_t;
endpackage

// File: rtl/pcm_mem_responder_if.sv
// pcm_mem_responder_if: CPU SRAM-style ports, Nios Avalon-MM port and perf counters
interface pcm_mem_responder_if #(parameter int N_CPU = 4, parameter int AW = 11, parameter int DW = 16);
  logic [N_CPU-1:0] cpu_ce_n, cpu_oe_n, cpu_we_n, cpu_ub_n, cpu_lb_n;
  logic [N_CPU*16-1:0] cpu_addr;
  logic [N_CPU*DW-1:0] cpu_wdata, cpu_rdata;
  logic [N_CPU-1:0] cpu_ready, cpu_err;
  logic [AW-1:0] mm_address;
  logic mm_chipselect, mm_clken, mm_write;
  logic [DW-1:0] mm_writedata, mm_readdata;
  logic [1:0] mm_byteenable;
  logic [N_CPU*16-1:0] perf_wait_cnt;
  modport master(
    output cpu_ce_n, cpu_oe_n, cpu_we_n, cpu_ub_n, cpu_lb_n, cpu_addr, cpu_wdata,
           mm_address, mm_chipselect, mm_clken, mm_write, mm_writedata, mm_byteenable,
    input cpu_rdata, cpu_ready, cpu_err, mm_readdata, perf_wait_cnt
  );
  modport slave(
    input cpu_ce_n, cpu_oe_n, cpu_we_n, cpu_ub_n, cpu_lb_n, cpu_addr, cpu_wdata,
          mm_address, mm_chipselect, mm_clken, mm_write, mm_writedata, mm_byteenable,
    output cpu_rdata, cpu_ready, cpu_err, mm_readdata, perf_wait_cnt
  );
endinterface

// File: rtl/pcm_ram.sv
// pcm_ram: single-port 2^AW x DW RAM with two byte lanes and registered read
module pcm_ram #(parameter int AW = 11, parameter int DW = 16) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic we,
  input  logic [1:0] be,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (en && we && be[0]) mem[addr][7:0] <= wd[7:0];
    if (en && we && be[1]) mem[addr][15:8] <= wd[15:8];
  end
  // read register holds its value between reads so Nios sees stable data
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (en && !we) q <= mem[addr];
endmodule

// File: rtl/pcm_mem_responder.sv
// pcm_mem_responder: round-robin CPU arbiter with fixed-priority Nios port; PCM_RESP_PERF_EN adds wait counters
module pcm_mem_responder
  import pcm_pkg::*;
#(parameter int N_CPU = PCM_N_CPU, parameter int AW = PCM_AW, parameter int DW = PCM_DW) (
  input logic clk,
  input logic reset,
  pcm_mem_responder_if.slave bus
);
  localparam int GW = $clog2(N_CPU);
  pcm_state_e state, state_nx;
  logic [N_CPU-1:0] req, elig, done, ack, ready, err;
  logic [GW-1:0] rr_ptr, grant, sel;
  logic any, nios, withdraw, oor, issue;
  pcm_op_t op;
  logic [N_CPU*DW-1:0] rdata;
  logic [DW-1:0] ram_q;
  assign req = ~bus.cpu_ce_n & (bus.cpu_oe_n ^ bus.cpu_we_n);
  assign elig = req & ~done;
  assign nios = bus.mm_chipselect & bus.mm_clken;
  assign withdraw = bus.cpu_ce_n[grant];
  assign oor = |op.addr[15:AW];
  assign issue = state == ACCESS && !withdraw && !nios;
  assign ack = (state == RESP && !withdraw) ? N_CPU'(1) << grant : '0;
  // descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    sel = rr_ptr;
    any = 1'b0;
    for (int k = N_CPU - 1; k >= 0; k--)
      if (elig[(int'(rr_ptr) + k) % N_CPU]) begin
        any = 1'b1;
        sel = GW'((int'(rr_ptr) + k) % N_CPU);
      end
  end
  always_comb
    state_nx = state == IDLE   ? (any ? ACCESS : IDLE) :
               state == ACCESS ? (withdraw ? IDLE : nios ? ACCESS : RESP) : IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      op <= '0;
      done <= '0;
      ready <= '0;
      err <= '0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      done <= ~bus.cpu_ce_n & (done | ack);
      ready <= ack;
      err <= oor ? ack : '0;
      if (state == IDLE && any) begin
        grant <= sel;
        op <= '{we: !bus.cpu_we_n[sel], addr: bus.cpu_addr[int'(sel)*16 +: 16],
                wdata: bus.cpu_wdata[int'(sel)*DW +: DW], ben: {!bus.cpu_ub_n[sel], !bus.cpu_lb_n[sel]}};
      end
      if (state == RESP) rr_ptr <= GW'((int'(grant) + 1) % N_CPU);
      if (|ack && (oor || !op.we)) rdata[int'(grant)*DW +: DW] <= oor ? '0 : ram_q;
    end
  pcm_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk(clk),
    .reset(reset),
    .en(nios || (issue && !oor)),
    .we(nios ? bus.mm_write : op.we),
    .be(nios ? bus.mm_byteenable : op.ben),
    .addr(nios ? bus.mm_address : op.addr[AW-1:0]),
    .wd(nios ? bus.mm_writedata : op.wdata),
    .q(ram_q)
  );
  assign bus.cpu_ready = ready;
  assign bus.cpu_err = err;
  assign bus.cpu_rdata = rdata;
  assign bus.mm_readdata = ram_q;
`ifdef PCM_RESP_PERF_EN
  for (genvar g = 0; g < N_CPU; g++) begin : g_perf
    logic [15:0] cnt;
    logic stall;
    assign stall = (elig[g] && !(state == IDLE ? any && sel == GW'(g) : grant == GW'(g))) ||
                   (state == ACCESS && grant == GW'(g) && nios);
    always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else cnt <= cnt + 16'(stall && cnt != 16'hFFFF);
    assign bus.perf_wait_cnt[g*16 +: 16] = cnt;
  end
`else
  assign bus.perf_wait_cnt = '0;
`endif
endmodule

// File: tb/tb_pcm_mem_responder.sv
// tb_pcm_mem_responder: directed stimulus with a scoreboard of expected CPU acks
module tb_pcm_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int k;
  typedef struct {int cpu; int cyc; bit chk; bit err; logic [15:0] data;} exp_t;
  exp_t sb[$];
`ifdef PCM_RESP_PERF_EN
  localparam logic [15:0] PERF1 = 16'd4;
`else
  localparam logic [15:0] PERF1 = 16'd0;
`endif
  pcm_mem_responder_if #(.N_CPU(4), .AW(11), .DW(16)) bus();
  pcm_mem_responder dut(.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (reset)
      for (int i = 0; i < 4; i++) begin
        if (bus.cpu_ready[i]) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL ack cpu%0d: unexpected ready at cycle %0d", i, cyc);
          end else begin
            e = sb.pop_front();
            if (e.cpu != i || e.cyc != cyc || bus.cpu_err[i] != e.err ||
                (e.chk && bus.cpu_rdata[i*16 +: 16] !== e.data)) begin
              fails++;
              $display("FAIL ack cpu%0d: got cycle %0d err %0b data %h, expected cpu%0d cycle %0d err %0b data %h",
                       i, cyc, bus.cpu_err[i], bus.cpu_rdata[i*16 +: 16], e.cpu, e.cyc, e.err, e.data);
            end
          end
        end else if (bus.cpu_err[i]) begin
          tests++;
          fails++;
          $display("FAIL err cpu%0d: err high without ready at cycle %0d", i, cyc);
        end
      end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cpu_req(int i, bit w, logic [15:0] a, logic [15:0] d, bit ub_n, bit lb_n);
    bus.cpu_addr[i*16 +: 16] = a;
    bus.cpu_wdata[i*16 +: 16] = d;
    bus.cpu_we_n[i] = !w;
    bus.cpu_oe_n[i] = w;
    bus.cpu_ub_n[i] = ub_n;
    bus.cpu_lb_n[i] = lb_n;
    bus.cpu_ce_n[i] = 1'b0;
  endtask

  task automatic cpu_rel(int i);
    bus.cpu_ce_n[i] = 1'b1;
    bus.cpu_oe_n[i] = 1'b1;
    bus.cpu_we_n[i] = 1'b1;
  endtask

  task automatic expect_ack(int i, int c, bit chk, bit err, logic [15:0] d);
    sb.push_back('{cpu: i, cyc: c, chk: chk, err: err, data: d});
  endtask

  task automatic wait_acks();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL ack timeout: %0d acks outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic nios_wr(logic [10:0] a, logic [15:0] d);
    bus.mm_address = a;
    bus.mm_writedata = d;
    bus.mm_byteenable = 2'b11;
    bus.mm_write = 1'b1;
    bus.mm_chipselect = 1'b1;
    bus.mm_clken = 1'b1;
    step();
    bus.mm_chipselect = 1'b0;
    bus.mm_clken = 1'b0;
    bus.mm_write = 1'b0;
  endtask

  task automatic nios_rd(logic [10:0] a, logic [15:0] exp, string name);
    bus.mm_address = a;
    bus.mm_write = 1'b0;
    bus.mm_chipselect = 1'b1;
    bus.mm_clken = 1'b1;
    step();
    bus.mm_chipselect = 1'b0;
    bus.mm_clken = 1'b0;
    check(name, 64'(bus.mm_readdata), 64'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step();
  endtask

  initial begin
    bus.cpu_ce_n = '1;
    bus.cpu_oe_n = '1;
    bus.cpu_we_n = '1;
    bus.cpu_ub_n = '0;
    bus.cpu_lb_n = '0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.mm_address = '0;
    bus.mm_chipselect = 1'b0;
    bus.mm_clken = 1'b0;
    bus.mm_write = 1'b0;
    bus.mm_writedata = '0;
    bus.mm_byteenable = '0;
    step(2);
    check("reset ready", 64'(bus.cpu_ready), 64'd0);
    check("reset err", 64'(bus.cpu_err), 64'd0);
    check("reset rdata", bus.cpu_rdata, 64'd0);
    check("reset mm_readdata", 64'(bus.mm_readdata), 64'd0);
    check("reset perf", bus.perf_wait_cnt, 64'd0);
    reset = 1'b1;
    step();
    // Nios write then uncontended CPU0 read
    nios_wr(11'h005, 16'hBEEF);
    cpu_req(0, 1'b0, 16'h0005, 16'h0, 1'b0, 1'b0);
    expect_ack(0, cyc + 3, 1'b1, 1'b0, 16'hBEEF);
    wait_acks();
    cpu_rel(0);
    nios_rd(11'h005, 16'hBEEF, "nios read 0x005");
    // all four CPUs from reset: acks at +3, +6, +9, +12
    for (int i = 0; i < 4; i++) nios_wr(11'(16 + i), 16'h1111 * 16'(i + 1));
    do_reset();
    for (int i = 0; i < 4; i++) cpu_req(i, 1'b0, 16'(16 + i), 16'h0, 1'b0, 1'b0);
    k = cyc;
    for (int i = 0; i < 4; i++) expect_ack(i, k + 3 * (i + 1), 1'b1, 1'b0, 16'h1111 * 16'(i + 1));
    wait_acks();
    step(3);
    for (int i = 0; i < 4; i++) cpu_rel(i);
    // low-lane-only write over 0xAAAA
    nios_wr(11'h020, 16'hAAAA);
    cpu_req(2, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0);
    expect_ack(2, cyc + 3, 1'b0, 1'b0, 16'h0);
    wait_acks();
    cpu_rel(2);
    step();
    cpu_req(2, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0);
    expect_ack(2, cyc + 3, 1'b1, 1'b0, 16'hAA34);
    wait_acks();
    cpu_rel(2);
    nios_rd(11'h020, 16'hAA34, "nios read lane write");
    // Nios owns the RAM for 4 cycles of CPU1's ACCESS
    do_reset();
    cpu_req(1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0);
    k = cyc;
    expect_ack(1, k + 7, 1'b1, 1'b0, 16'hAA34);
    step();
    bus.mm_address = 11'h005;
    bus.mm_write = 1'b0;
    bus.mm_chipselect = 1'b1;
    bus.mm_clken = 1'b1;
    step(4);
    bus.mm_chipselect = 1'b0;
    bus.mm_clken = 1'b0;
    wait_acks();
    cpu_rel(1);
    check("perf cpu1", 64'(bus.perf_wait_cnt[31:16]), 64'(PERF1));
    // out-of-range accesses from CPU3
    cpu_req(3, 1'b0, 16'h0005, 16'h0, 1'b0, 1'b0);
    expect_ack(3, cyc + 3, 1'b1, 1'b0, 16'hBEEF);
    wait_acks();
    cpu_rel(3);
    nios_wr(11'h000, 16'h0F0F);
    cpu_req(3, 1'b1, 16'h0800, 16'h5555, 1'b0, 1'b0);
    expect_ack(3, cyc + 3, 1'b0, 1'b1, 16'h0);
    wait_acks();
    cpu_rel(3);
    nios_rd(11'h000, 16'h0F0F, "oor write no effect");
    cpu_req(3, 1'b0, 16'h0800, 16'h0, 1'b0, 1'b0);
    expect_ack(3, cyc + 3, 1'b1, 1'b1, 16'h0000);
    wait_acks();
    cpu_rel(3);
    // reset during ACCESS drops the pending write
    nios_wr(11'h030, 16'h3333);
    cpu_req(0, 1'b1, 16'h0030, 16'h7777, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check("async reset ready", 64'(bus.cpu_ready), 64'd0);
    check("async reset err", 64'(bus.cpu_err), 64'd0);
    check("async reset rdata", bus.cpu_rdata, 64'd0);
    check("async reset mm_readdata", 64'(bus.mm_readdata), 64'd0);
    check("async reset perf", bus.perf_wait_cnt, 64'd0);
    step();
    cpu_rel(0);
    step();
    reset = 1'b1;
    step();
    nios_rd(11'h030, 16'h3333, "reset drops write");
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pcm_mem_responder.md
# pcm_mem_responder

- Memory-side responder for the four PCM CPU cores' SRAM-style ports (active-low CE/OE/WE/UB/LB, 16-bit address, 16-bit data).
- Services all four ports from one shared 2^AW x DW on-chip memory, using round-robin arbitration.
- The Nios PCM Avalon-MM slave port (pcm_mem_mm_*) has fixed priority on the same memory.
- Sits between the CPU instances and the Nios system at SoC top level; replaces direct CPU-to-memory wiring.

## Interface
Parameters:
- N_CPU, 4, number of CPU ports
- AW, 11, memory word-address width
- DW, 16, data width (byte lanes fixed at 2)

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- cpu_ce_n  in  N_CPU  per-CPU chip enable, active low
- cpu_oe_n  in  N_CPU  per-CPU read strobe, active low
- cpu_we_n  in  N_CPU  per-CPU write strobe, active low
- cpu_ub_n  in  N_CPU  byte enable for bits [15:8], active low
- cpu_lb_n  in  N_CPU  byte enable for bits [7:0], active low
- cpu_addr  in  N_CPU*16  per-CPU word address, CPU i at [16i+15:16i]
- cpu_wdata  in  N_CPU*DW  per-CPU write data (top level resolves tristate)
- cpu_rdata  out  N_CPU*DW  per-CPU read data, held until that CPU's next ack
- cpu_ready  out  N_CPU  one-cycle completion pulse per CPU
- cpu_err  out  N_CPU  high together with cpu_ready when the address was out of range
- mm_address  in  AW  Nios word address
- mm_chipselect, mm_clken, mm_write  in  1 each  Nios access controls
- mm_writedata  in  DW  Nios write data
- mm_byteenable  in  2  Nios byte enables, active high
- mm_readdata  out  DW  Nios read data, latency 1
- perf_wait_cnt  out  N_CPU*16  per-CPU wait counters (see Configuration)

## Operation
**Requests and eligibility**
- CPU i requests when ce_n=0 and exactly one of oe_n, we_n is 0. Both low or both high means no request.
- Per-CPU `done` flag is set on ack and cleared when ce_n returns high. A CPU with `done` set is not eligible, so each CE assertion is serviced once.

**Arbitration FSM** (states IDLE, ACCESS, RESP)
- IDLE: among eligible CPUs, grant the first at or after `rr_ptr` (circular). Register grant index, op, address, data and byte enables. Go to ACCESS.
- ACCESS: issue the memory op unless Nios owns the memory this cycle (mm_chipselect & mm_clken). If Nios owns it, stay in ACCESS. After issue, go to RESP.
- RESP: capture read data into cpu_rdata[grant]. Pulse cpu_ready[grant], set done[grant], set rr_ptr = grant+1 mod N_CPU, return to IDLE.

**Write and address rules**
- Write lanes: ub_n=0 writes [15:8]; lb_n=0 writes [7:0]. A write with both lanes disabled is a no-op but is still acked.
- Reads return the full word regardless of lane enables.
- Out of range means cpu_addr[15:AW] != 0. Such a request is not issued to memory; read data is 16'h0000 and cpu_err pulses with ready. Timing is unchanged.

**Nios port and withdrawal**
- Nios access is issued in the same cycle it is presented; Nios is never stalled.
- Withdrawal before issue: if the granted CPU raises ce_n while in ACCESS and not yet issued, abort to IDLE with no memory op and no ready, and leave rr_ptr unchanged.
- Withdrawal after issue: the op completes, but ready is suppressed.

## Timing
- Reset values: cpu_rdata=0, cpu_ready=0, cpu_err=0, mm_readdata=0, perf_wait_cnt=0, done=0, rr_ptr=0, state=IDLE.
- Uncontended CPU access: request first sampled in cycle t, ready at t+3 (IDLE t, ACCESS t+1, RESP t+2, pulse visible in t+3).
- Each cycle of Nios ownership during ACCESS adds one cycle.
- Worst case with all four CPUs requesting and no Nios traffic: 12 cycles.
- Nios read: mm_readdata is valid the cycle after chipselect & clken & !write.
- Nios write: committed at the same edge as the access.
- Same-address conflict: a Nios write and a CPU read issued on consecutive cycles are ordered by issue cycle; no bypass is needed because the port is single.
- No back-to-back grant to the same CPU, because done must clear first.

## Configuration
- PCM_RESP_PERF_EN defined: perf_wait_cnt[i] increments each cycle CPU i is eligible but not granted, or granted but blocked by Nios. Counters saturate at 16'hFFFF and clear only on reset.
- PCM_RESP_PERF_EN undefined: perf_wait_cnt is tied to 0 and no counter logic is built.

## Structure
- Package pcm_pkg holds:
  - `pcm_state_e` (IDLE, ACCESS, RESP)
  - `pcm_op_t` struct (we, addr, wdata, ben)
  - constants PCM_N_CPU, PCM_AW, PCM_DW
- Sub-module pcm_ram: single-port 2^AW x 16 synchronous RAM with 2 byte enables, registered read, inference-friendly.
- The arbiter mux (Nios vs. granted CPU) drives pcm_ram.

## Test plan
- Reset release, CPU0 reads addr 0x0005 after Nios wrote 0xBEEF there → cpu_rdata[0]=0xBEEF, cpu_ready[0] pulses 3 cycles after request, one cycle wide.
- All four CPUs assert read simultaneously from reset → acks in order CPU0, 1, 2, 3 at cycles 3, 6, 9, 12; each pulses once while CE stays low.
- CPU2 writes 0x1234 with ub_n=1, lb_n=0 over existing 0xAAAA → subsequent read returns 0xAA34.
- Nios holds chipselect & clken for 4 cycles during CPU1's ACCESS → CPU1 ready delayed by exactly 4 cycles. With PCM_RESP_PERF_EN, perf_wait_cnt[1]=4.
- CPU3 accesses 0x0800 → no memory change, cpu_rdata[3]=0, cpu_err[3] and cpu_ready[3] pulse together.
- Reset asserted while in ACCESS → all outputs return to reset values immediately; pending write not committed.
